// File: rtl/vote_recorder.sv
// ---------------------------------------------------------------------------
// vote_recorder
// Voting-mode front end of the voting machine. It conditions the four raw
// candidate buttons and counts accepted votes per candidate.
// Each button goes through a 2-flop synchronizer, then a debouncer, then a
// rising-edge detector. A small FSM accepts one unambiguous press at a time.
// After an accepted vote it locks out further votes for a hold window. It then
// waits for every button to be released before it accepts the next press.
//
// Ports
//   clk               clock
//   rst               synchronous active-high reset
//   mode              0 = voting, 1 = result display (no counting)
//   btn1..btn4        raw asynchronous candidate buttons, active-high
//   valid_vote_casted one-cycle pulse per accepted vote
//   invalid_vote      one-cycle pulse per rejected press
//   busy              high while in HOLD or WAIT_REL
//   cand_vote1..4     registered, saturating per-candidate tallies
// ---------------------------------------------------------------------------
module vote_recorder #(
    parameter int CNT_W       = 8,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int HOLD_CYCLES = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             btn1,
    input  logic             btn2,
    input  logic             btn3,
    input  logic             btn4,
    output logic             valid_vote_casted,
    output logic             invalid_vote,
    output logic             busy,
    output logic [CNT_W-1:0] cand_vote1,
    output logic [CNT_W-1:0] cand_vote2,
    output logic [CNT_W-1:0] cand_vote3,
    output logic [CNT_W-1:0] cand_vote4
);

    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    logic [3:0]             btn_raw_s;
    logic [3:0]             sync1_r;
    logic [3:0]             sync2_r;
    logic [3:0]             level_r;
    logic [3:0]             level_d_r;
    logic [3:0][DEB_W-1:0]  deb_cnt_r;
    logic [3:0]             press_s;
    logic [3:0]             others_s;
    logic                   single_s;
    logic                   sat_s;
    logic                   mode_d_r;

    state_t                 state_r;
    state_t                 state_s;
    logic [HOLD_W-1:0]      hold_r;
    logic [HOLD_W-1:0]      hold_s;
    logic [CNT_W-1:0]       tally_r [4];
    logic [CNT_W-1:0]       tally_s [4];
    logic                   valid_r;
    logic                   valid_s;
    logic                   invalid_r;
    logic                   invalid_s;
    logic                   busy_r;

    assign btn_raw_s = {btn4, btn3, btn2, btn1};

    // Two-flop synchronizer for the asynchronous buttons.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer: the level flips only after DEB_CYCLES disagreeing cycles in a row.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r   <= 4'b0000;
            level_d_r <= 4'b0000;
            deb_cnt_r <= {4{{DEB_W{1'b0}}}};
        end else begin
            level_d_r <= level_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] != level_r[i]) begin
                    if (deb_cnt_r[i] == DEB_LAST) begin
                        level_r[i]   <= sync2_r[i];
                        deb_cnt_r[i] <= {DEB_W{1'b0}};
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt_r[i] <= {DEB_W{1'b0}};
                end
            end
        end
    end

    // Press detection and classification: single press, other buttons held, and saturation.
    always_comb begin
        press_s  = level_r & ~level_d_r;
        others_s = level_r & ~press_s;
        single_s = (press_s != 4'b0000) && ((press_s & (press_s - 4'b0001)) == 4'b0000);
        sat_s    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (press_s[i] && (tally_r[i] == CNT_MAX)) begin
                sat_s = 1'b1;
            end else begin
                sat_s = sat_s;
            end
        end
    end

    // FSM next state, hold counter and tally updates.
    // Result-display mode parks the FSM in IDLE. When the machine returns to
    // voting, it goes through WAIT_REL, so a button held during display is never counted.
    always_comb begin
        state_s   = state_r;
        hold_s    = hold_r;
        tally_s   = tally_r;
        valid_s   = 1'b0;
        invalid_s = 1'b0;
        if (mode) begin
            state_s = IDLE;
            hold_s  = {HOLD_W{1'b0}};
        end else if (mode_d_r) begin
            state_s = WAIT_REL;
            hold_s  = {HOLD_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (press_s == 4'b0000) begin
                        state_s = IDLE;
                    end else if (single_s && (others_s == 4'b0000) && !sat_s) begin
                        for (int i = 0; i < 4; i++) begin
                            if (press_s[i]) begin
                                tally_s[i] = tally_r[i] + CNT_W'(1);
                            end else begin
                                tally_s[i] = tally_r[i];
                            end
                        end
                        valid_s = 1'b1;
                        hold_s  = HOLD_LOAD;
                        state_s = HOLD;
                    end else begin
                        invalid_s = 1'b1;
                        state_s   = WAIT_REL;
                    end
                end
                HOLD: begin
                    if (hold_r == {HOLD_W{1'b0}}) begin
                        state_s = WAIT_REL;
                    end else begin
                        hold_s = hold_r - HOLD_W'(1);
                    end
                end
                WAIT_REL: begin
                    if (level_r == 4'b0000) begin
                        state_s = IDLE;
                    end else begin
                        state_s = WAIT_REL;
                    end
                end
                default: begin
                    state_s = IDLE;
                    hold_s  = {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            hold_r    <= {HOLD_W{1'b0}};
            mode_d_r  <= 1'b0;
            valid_r   <= 1'b0;
            invalid_r <= 1'b0;
            busy_r    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tally_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            state_r   <= state_s;
            hold_r    <= hold_s;
            mode_d_r  <= mode;
            valid_r   <= valid_s;
            invalid_r <= invalid_s;
            busy_r    <= (state_s != IDLE);
            for (int i = 0; i < 4; i++) begin
                tally_r[i] <= tally_s[i];
            end
        end
    end

    assign valid_vote_casted = valid_r;
    assign invalid_vote      = invalid_r;
    assign busy              = busy_r;
    assign cand_vote1        = tally_r[0];
    assign cand_vote2        = tally_r[1];
    assign cand_vote3        = tally_r[2];
    assign cand_vote4        = tally_r[3];

endmodule

// File: tb/tb_vote_recorder.sv
// ---------------------------------------------------------------------------
// tb_vote_recorder
// Directed, scoreboard-checked bench for vote_recorder.
// The parameters are CNT_W=4, DEB_CYCLES=4 and HOLD_CYCLES=10.
// Stimulus pushes the expected pulse and tallies before it drives a press.
// A negedge monitor pops an entry and compares it each time a pulse appears.
// ---------------------------------------------------------------------------
module tb_vote_recorder;

    typedef struct {
        bit          is_valid;
        logic [15:0] tallies;   // {t4, t3, t2, t1}
        int          cyc;       // expected edge index, -1 = don't care
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic       btn1 = 1'b0;
    logic       btn2 = 1'b0;
    logic       btn3 = 1'b0;
    logic       btn4 = 1'b0;
    logic       valid_vote_casted;
    logic       invalid_vote;
    logic       busy;
    logic [3:0] cand_vote1;
    logic [3:0] cand_vote2;
    logic [3:0] cand_vote3;
    logic [3:0] cand_vote4;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    vote_recorder #(
        .CNT_W      (4),
        .DEB_CYCLES (4),
        .HOLD_CYCLES(10)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mode             (mode),
        .btn1             (btn1),
        .btn2             (btn2),
        .btn3             (btn3),
        .btn4             (btn4),
        .valid_vote_casted(valid_vote_casted),
        .invalid_vote     (invalid_vote),
        .busy             (busy),
        .cand_vote1       (cand_vote1),
        .cand_vote2       (cand_vote2),
        .cand_vote3       (cand_vote3),
        .cand_vote4       (cand_vote4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pk(input int t1, input int t2, input int t3, input int t4);
        logic [3:0] a, b, c, d;
        a = t1[3:0]; b = t2[3:0]; c = t3[3:0]; d = t4[3:0];
        return {d, c, b, a};
    endfunction

    // Monitor: every pulse must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t       e;
        logic [15:0] act;
        if (!rst && (valid_vote_casted || invalid_vote)) begin
            act = {cand_vote4, cand_vote3, cand_vote2, cand_vote1};
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: valid=%0b invalid=%0b tallies=%h at edge %0d, none required",
                         valid_vote_casted, invalid_vote, act, cyc);
            end else begin
                e = exp_q.pop_front();
                if ((valid_vote_casted == e.is_valid) && (invalid_vote == !e.is_valid) &&
                    (act == e.tallies) && ((e.cyc < 0) || (e.cyc == cyc))) begin
                    passed++;
                end else begin
                    $display("FAIL pulse: valid=%0b invalid=%0b tallies=%h edge=%0d, required valid=%0b tallies=%h edge=%0d",
                             valid_vote_casted, invalid_vote, act, cyc, e.is_valid, e.tallies, e.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic expect_pulse(input bit v, input logic [15:0] t, input int c);
        exp_t e;
        e.is_valid = v;
        e.tallies  = t;
        e.cyc      = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    // Watchdog: make sure the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset state
        tick(3);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tallies", {16'd0, cand_vote4, cand_vote3, cand_vote2, cand_vote1}, 32'd0);
        check("rst_pulses", {30'd0, valid_vote_casted, invalid_vote}, 32'd0);
        rst = 1'b0;
        tick(2);

        // 1: single press on btn2, exact latency and busy window
        c = cyc;
        expect_pulse(1'b1, pk(0, 1, 0, 0), c + 8);
        btn2 = 1'b1;
        tick(20);
        btn2 = 1'b0;
        tick(7);
        check("t1_busy_before_release", {31'd0, busy}, 32'd1);
        tick(1);
        check("t1_idle_after_release", {31'd0, busy}, 32'd0);
        tick(3);

        // 2: a 3-cycle glitch is filtered; a real press then counts
        btn1 = 1'b1;
        tick(3);
        btn1 = 1'b0;
        tick(15);
        check("t2_glitch_no_tally", {28'd0, cand_vote1}, 32'd0);
        check("t2_glitch_no_busy", {31'd0, busy}, 32'd0);
        expect_pulse(1'b1, pk(1, 1, 0, 0), -1);
        btn1 = 1'b1;
        tick(8);
        btn1 = 1'b0;
        wait_idle("t2_idle");
        tick(3);

        // 3: two buttons at once are rejected
        expect_pulse(1'b0, pk(1, 1, 0, 0), -1);
        btn1 = 1'b1;
        btn3 = 1'b1;
        tick(8);
        check("t3_busy_after_invalid", {31'd0, busy}, 32'd1);
        btn1 = 1'b0;
        btn3 = 1'b0;
        wait_idle("t3_idle");
        tick(3);

        // 4: btn4 saturates at 15; the 16th press is invalid
        for (int k = 1; k <= 16; k++) begin
            if (k <= 15) begin
                expect_pulse(1'b1, pk(1, 1, 0, k), -1);
            end else begin
                expect_pulse(1'b0, pk(1, 1, 0, 15), -1);
            end
            btn4 = 1'b1;
            tick(8);
            btn4 = 1'b0;
            wait_idle("t4_idle");
            tick(2);
        end
        check("t4_saturated", {28'd0, cand_vote4}, 32'd15);

        // 5a: a re-press during HOLD is ignored
        expect_pulse(1'b1, pk(1, 2, 0, 15), -1);
        btn2 = 1'b1;
        tick(6);
        btn2 = 1'b0;
        tick(4);
        btn2 = 1'b1;
        tick(8);
        btn2 = 1'b0;
        wait_idle("t5_hold_idle");
        tick(3);
        check("t5_single_vote", {28'd0, cand_vote2}, 32'd2);

        // 5b: a button held through result display is not counted on return
        mode = 1'b1;
        btn3 = 1'b1;
        tick(15);
        check("t5_display_no_busy", {31'd0, busy}, 32'd0);
        mode = 1'b0;
        tick(3);
        check("t5_wait_rel_busy", {31'd0, busy}, 32'd1);
        tick(10);
        check("t5_held_not_counted", {28'd0, cand_vote3}, 32'd0);
        btn3 = 1'b0;
        wait_idle("t5_mode_idle");
        tick(3);
        expect_pulse(1'b1, pk(1, 2, 1, 15), -1);
        btn3 = 1'b1;
        tick(8);
        btn3 = 1'b0;
        wait_idle("t5_btn3_idle");
        tick(3);

        // 6: reset in the middle of HOLD clears everything
        expect_pulse(1'b1, pk(2, 2, 1, 15), -1);
        btn1 = 1'b1;
        tick(11);
        btn1 = 1'b0;
        rst  = 1'b1;
        tick(2);
        rst  = 1'b0;
        tick(1);
        check("t6_tallies_cleared", {16'd0, cand_vote4, cand_vote3, cand_vote2, cand_vote1}, 32'd0);
        check("t6_busy_cleared", {31'd0, busy}, 32'd0);
        tick(2);
        expect_pulse(1'b1, pk(0, 0, 0, 1), -1);
        btn4 = 1'b1;
        tick(8);
        btn4 = 1'b0;
        wait_idle("t6_idle");
        tick(20);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
